product_accumulator: RTL and testbench

Sequential accumulator sitting directly downstream of the 16x16 unsigned multiplier: it consumes a stream of 32-bit products and sums them into dot-product results. Each frame is N_TERMS products, or fewer if terminated by `in_last`. The completed sum, a saturation flag and the term count are presented on a valid/ready output port.

---
 rtl/product_accumulator.sv | 96 +++++++++
 tb/tb_product_accumulator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Saturating accumulator for a stream of 32-bit unsigned products.
// Sums up to N_TERMS products per frame and presents the result on a valid/ready port.
module product_accumulator #(
    parameter int ACC_W   = 40,
    parameter int N_TERMS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [7:0]       out_count
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic [ACC_W:0]   sum_wide;
    logic             accept;

    assign in_ready  = !rst && (state_reg == ST_ACC);
    assign out_valid = (state_reg == ST_DONE);
    assign accept    = in_valid && in_ready && !clear;

    // One extra bit so the carry-out flags saturation.
    assign sum_wide = {1'b0, acc_reg} + {{(ACC_W + 1 - 32){1'b0}}, in_prod};

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        if (clear) begin
            state_next = ST_ACC;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_ACC: begin
                    if (accept) begin
                        acc_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
                        ovf_next = ovf_reg | sum_wide[ACC_W];
                        cnt_next = cnt_reg + 8'd1;
                        if (in_last || (cnt_reg == LAST_CNT)) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_next = ST_ACC;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: state_next = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ACC;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Accumulator registers are frozen in DONE, so they serve directly as the result.
    assign out_sum   = acc_reg;
    assign out_ovf   = ovf_reg;
    assign out_count = cnt_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two widths driven in parallel, checked against a frame-level model.
module tb_product_accumulator;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [39:0] a_out_sum;
    logic [7:0]  a_out_count;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [32:0] b_out_sum;
    logic [7:0]  b_out_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(40), .N_TERMS(N)) u_dut40 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_sum(a_out_sum), .out_ovf(a_out_ovf), .out_count(a_out_count)
    );

    product_accumulator #(.ACC_W(33), .N_TERMS(N)) u_dut33 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_sum(b_out_sum), .out_ovf(b_out_ovf), .out_count(b_out_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: exact (unsaturated) sum of accepted terms; saturation derived per width.
    longint unsigned m_sum  = 0;
    int              m_cnt  = 0;
    bit              m_pend = 1'b0;
    bit              armed  = 1'b0;

    function automatic logic [63:0] sat_of(input longint unsigned s, input int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 64'd1;
        return (s > mx) ? mx : s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_sum = 0; m_cnt = 0; m_pend = 1'b0; armed = 1'b1;
        end else if (clear) begin
            m_sum = 0; m_cnt = 0; m_pend = 1'b0;
        end else if (m_pend) begin
            if (out_ready) begin
                m_sum = 0; m_cnt = 0; m_pend = 1'b0;
            end
        end else if (in_valid) begin
            m_sum += longint'(in_prod);
            m_cnt++;
            if (in_last || m_cnt == N) m_pend = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m40_in_ready",  64'(a_in_ready),  64'(!rst && !m_pend));
            chk("m40_out_valid", 64'(a_out_valid), 64'(m_pend));
            chk("m33_in_ready",  64'(b_in_ready),  64'(!rst && !m_pend));
            chk("m33_out_valid", 64'(b_out_valid), 64'(m_pend));
            if (m_pend) begin
                chk("m40_out_sum",   64'(a_out_sum),   sat_of(m_sum, 40));
                chk("m40_out_ovf",   64'(a_out_ovf),   64'(m_sum > sat_of(m_sum, 40)));
                chk("m40_out_count", 64'(a_out_count), 64'(m_cnt));
                chk("m33_out_sum",   64'(b_out_sum),   sat_of(m_sum, 33));
                chk("m33_out_ovf",   64'(b_out_ovf),   64'(m_sum > sat_of(m_sum, 33)));
                chk("m33_out_count", 64'(b_out_count), 64'(m_cnt));
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] p, input logic l);
        in_valid = v;
        in_prod  = p;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_sum", 64'(a_out_sum), 64'd0);
        chk("rst_out_count", 64'(a_out_count), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);

        // Full frame 1..8
        out_ready = 1'b1;
        for (int i = 1; i <= N; i++) step(1'b1, 32'(i), 1'b0);
        chk("full_valid", 64'(a_out_valid), 64'd1);
        chk("full_sum", 64'(a_out_sum), 64'd36);
        chk("full_count", 64'(a_out_count), 64'd8);
        chk("full_ovf", 64'(a_out_ovf), 64'd0);
        chk("full_in_ready", 64'(a_in_ready), 64'd0);
        step(1'b0, 32'd0, 1'b0);
        chk("full_drained", 64'(a_out_valid), 64'd0);
        chk("full_drain_ready", 64'(a_in_ready), 64'd1);

        // Early last
        step(1'b1, 32'd100, 1'b0);
        step(1'b1, 32'd200, 1'b1);
        chk("early_sum", 64'(a_out_sum), 64'd300);
        chk("early_count", 64'(a_out_count), 64'd2);
        step(1'b0, 32'd0, 1'b0);
        step(1'b1, 32'd5, 1'b1);
        chk("early_next_sum", 64'(a_out_sum), 64'd5);
        chk("early_next_count", 64'(a_out_count), 64'd1);
        step(1'b0, 32'd0, 1'b0);

        // Saturation
        step(1'b1, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 1'b1);
        chk("sat33_sum", 64'(b_out_sum), 64'h1_FFFF_FFFF);
        chk("sat33_ovf", 64'(b_out_ovf), 64'd1);
        chk("sat40_sum", 64'(a_out_sum), 64'h2_FFFF_FFFD);
        chk("sat40_ovf", 64'(a_out_ovf), 64'd0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b1, 32'd1, 1'b1);
        chk("sat_next_ovf", 64'(b_out_ovf), 64'd0);
        chk("sat_next_sum", 64'(b_out_sum), 64'd1);
        step(1'b0, 32'd0, 1'b0);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= N; i++) step(1'b1, 32'(i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'd9, 1'b1);
            chk("bp_sum", 64'(a_out_sum), 64'd36);
            chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step(1'b1, 32'd9, 1'b1);
        chk("bp_released", 64'(a_out_valid), 64'd0);
        out_ready = 1'b0;
        step(1'b1, 32'd9, 1'b1);
        chk("bp_next_sum", 64'(a_out_sum), 64'd9);
        chk("bp_next_count", 64'(a_out_count), 64'd1);
        out_ready = 1'b1;
        step(1'b0, 32'd0, 1'b0);

        // Clear mid-frame masks the offered term
        for (int i = 0; i < 3; i++) step(1'b1, 32'd50, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_prod  = 32'd50;
        #1;
        chk("clr_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #1;
        clear = 1'b0;
        for (int i = 0; i < N; i++) step(1'b1, 32'd1, 1'b0);
        chk("clr_sum", 64'(a_out_sum), 64'd8);
        chk("clr_count", 64'(a_out_count), 64'd8);
        step(1'b0, 32'd0, 1'b0);

        // Clear in DONE discards the result
        out_ready = 1'b0;
        step(1'b1, 32'd3, 1'b1);
        chk("clrd_valid", 64'(a_out_valid), 64'd1);
        clear = 1'b1;
        step(1'b0, 32'd0, 1'b0);
        clear = 1'b0;
        chk("clrd_dropped", 64'(a_out_valid), 64'd0);
        chk("clrd_in_ready", 64'(a_in_ready), 64'd1);

        // Reset mid-DONE
        step(1'b1, 32'd7, 1'b1);
        chk("rstd_valid", 64'(a_out_valid), 64'd1);
        rst = 1'b1;
        step(1'b0, 32'd0, 1'b0);
        chk("rstd_out_valid", 64'(a_out_valid), 64'd0);
        chk("rstd_out_sum", 64'(a_out_sum), 64'd0);
        chk("rstd_out_count", 64'(a_out_count), 64'd0);
        chk("rstd_out_ovf", 64'(a_out_ovf), 64'd0);
        chk("rstd_in_ready", 64'(a_in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rstd_release_ready", 64'(a_in_ready), 64'd1);
        out_ready = 1'b1;
        step(1'b1, 32'd4, 1'b1);
        chk("rstd_new_sum", 64'(a_out_sum), 64'd4);
        chk("rstd_new_count", 64'(a_out_count), 64'd1);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
